// File: rtl/blackhole_input_pkg.sv
// Shared types and bit layouts for the blackhole input controller.
// Canonical direction/fire vector is the common currency between sources.
package blackhole_input_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_KBD  = 2'd1,
      OWN_JOY0 = 2'd2,
      OWN_JOY1 = 2'd3
   } owner_e;

   localparam int KB_FIRE   = 0;
   localparam int KB_START1 = 1;
   localparam int KB_START2 = 2;
   localparam int KB_COIN   = 3;
   localparam int KB_UP     = 4;
   localparam int KB_DOWN   = 5;
   localparam int KB_LEFT   = 6;
   localparam int KB_RIGHT  = 7;

   localparam int JS_RIGHT = 0;
   localparam int JS_LEFT  = 1;
   localparam int JS_DOWN  = 2;
   localparam int JS_UP    = 3;
   localparam int JS_FIRE  = 4;

   localparam int SYNC_STAGES = 2;

   typedef struct packed {
      logic u;
      logic d;
      logic l;
      logic r;
      logic f;
   } canon_t;

endpackage

// File: rtl/input_pulse_gen.sv
// Frame-timed pulse from a synchronized key; one shot per press.
// Re-arms only after the key is observed low on a valid synchronized sample.
module input_pulse_gen #(
   parameter int N = 4
) (
   input  logic clk_sys,
   input  logic res_n_i,
   input  logic key,
   input  logic arm_en,
   input  logic frame_tick,
   output logic pulse
);

   localparam int CW = $clog2(N + 1);

   logic [CW-1:0] cnt;
   logic          armed;

   // Drop happens on the tick after the count hits zero, giving N..N+1 frames.
   always_ff @(posedge clk_sys or negedge res_n_i) begin
      if (!res_n_i) begin
         pulse <= 1'b0;
         cnt   <= '0;
         armed <= 1'b0;
      end else if (pulse) begin
         if (frame_tick) begin
            if (cnt == '0) pulse <= 1'b0;
            else           cnt   <= cnt - CW'(1);
         end
      end else if (armed && key) begin
         pulse <= 1'b1;
         cnt   <= CW'(N);
         armed <= 1'b0;
      end else if (arm_en && !key) begin
         armed <= 1'b1;
      end
   end

endmodule

// File: rtl/blackhole_input_ctrl.sv
// Input controller: synchronizes MiST sources, arbitrates a single owner,
// remaps orientation and drives the galaxian P1/P2 control words.
module blackhole_input_ctrl
   import blackhole_input_pkg::*;
#(
   parameter int COIN_FRAMES  = 4,
   parameter int START_FRAMES = 2,
   parameter int IDLE_FRAMES  = 120
) (
   input  logic       clk_sys,
   input  logic       res_n_i,
   input  logic [9:0] kbjoy,
   input  logic [7:0] joystick_0,
   input  logic [7:0] joystick_1,
   input  logic       rotate,
   input  logic       vblank,
   output logic [6:0] p1_csjudlr,
   output logic [6:0] p2_csjudlr,
   output logic [1:0] owner
);

   localparam int SW = 28;
   localparam logic [7:0] IDLE_MAX = 8'(IDLE_FRAMES);

   logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
   logic [SYNC_STAGES-1:0]         vld_pipe;
   logic [SW-1:0]                  sync_s;
   logic [9:0]                     kb_s;
   logic [7:0]                     j0_s, j1_s;
   logic                           rot_s, vb_s, vb_d, frame_tick, sync_vld;

   always_ff @(posedge clk_sys or negedge res_n_i) begin
      if (!res_n_i) begin
         sync_q   <= '0;
         vld_pipe <= '0;
         vb_d     <= 1'b0;
      end else begin
         sync_q[0] <= {vblank, rotate, joystick_1, joystick_0, kbjoy};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
         vb_d      <= vb_s;
      end
   end

   assign sync_s     = sync_q[SYNC_STAGES-1];
   assign sync_vld   = vld_pipe[SYNC_STAGES-1];
   assign kb_s       = sync_s[9:0];
   assign j0_s       = sync_s[17:10];
   assign j1_s       = sync_s[25:18];
   assign rot_s      = sync_s[26];
   assign vb_s       = sync_s[27];
   assign frame_tick = vb_s & ~vb_d;

   logic unused_bits;
   assign unused_bits = ^{kb_s[9:8], j0_s[7:5], j1_s[7:5]};

   // Indexed by owner code so the owner's vector is a direct lookup; slot 0 is NONE.
   canon_t [3:0] src;
   logic   [3:0] act;

   always_comb begin
      src[0] = '0;
      src[1] = {kb_s[KB_UP], kb_s[KB_DOWN], kb_s[KB_LEFT], kb_s[KB_RIGHT], kb_s[KB_FIRE]};
      src[2] = {j0_s[JS_UP], j0_s[JS_DOWN], j0_s[JS_LEFT], j0_s[JS_RIGHT], j0_s[JS_FIRE]};
      src[3] = {j1_s[JS_UP], j1_s[JS_DOWN], j1_s[JS_LEFT], j1_s[JS_RIGHT], j1_s[JS_FIRE]};
      for (int i = 0; i < 4; i++) act[i] = |src[i];
   end

   owner_e     state, state_nx;
   logic [7:0] idle_cnt, idle_nx, idle_inc;

   assign idle_inc = idle_cnt + 8'd1;

   always_ff @(posedge clk_sys or negedge res_n_i) begin
      if (!res_n_i) begin
         state    <= OWN_NONE;
         idle_cnt <= '0;
      end else begin
         state    <= state_nx;
         idle_cnt <= idle_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idle_nx  = idle_cnt;
      case (state)
         OWN_NONE: begin
            idle_nx = '0;
            if      (act[1]) state_nx = OWN_KBD;
            else if (act[2]) state_nx = OWN_JOY0;
            else if (act[3]) state_nx = OWN_JOY1;
         end
         default: begin
            // Owner activity beats a coincident release tick.
            if (act[state]) begin
               idle_nx = '0;
            end else if (frame_tick) begin
               if (idle_inc == IDLE_MAX) begin
                  state_nx = OWN_NONE;
                  idle_nx  = '0;
               end else begin
                  idle_nx = idle_inc;
               end
            end
         end
      endcase
   end

   canon_t sel, dir, out_q;

   always_comb begin
      sel = src[state_nx];
      dir = sel;
      if (rot_s) begin
         dir.u = sel.l;
         dir.d = sel.r;
         dir.l = sel.d;
         dir.r = sel.u;
      end
   end

   always_ff @(posedge clk_sys or negedge res_n_i) begin
      if (!res_n_i) out_q <= '0;
      else          out_q <= dir;
   end

   logic [2:0] key_s, pulse;
   assign key_s = {kb_s[KB_START2], kb_s[KB_START1], kb_s[KB_COIN]};

   for (genvar g = 0; g < 3; g++) begin : g_pulse
      input_pulse_gen #(
         .N(g == 0 ? COIN_FRAMES : START_FRAMES)
      ) u_pulse (
         .clk_sys   (clk_sys),
         .res_n_i   (res_n_i),
         .key       (key_s[g]),
         .arm_en    (sync_vld),
         .frame_tick(frame_tick),
         .pulse     (pulse[g])
      );
   end

   assign p1_csjudlr = {pulse[0], pulse[1], out_q.f, 2'b00, out_q.l, out_q.r};
   assign p2_csjudlr = {1'b0, pulse[2], out_q.f, 2'b00, out_q.d, out_q.u};
   assign owner      = state;

endmodule

// File: doc/blackhole_input_ctrl.md
# blackhole_input_ctrl

Input controller between the MiST I/O sources (keyboard decoder, joystick_0, joystick_1) and the galaxian core's `P1_CSJUDLR`/`P2_CSJUDLR` ports. It synchronizes all inputs and arbitrates ownership of the single control set among the three sources. It shapes coin/start into frame-timed pulses, applies the upright/normal orientation remap, and registers both packed control words.

## Interface
Parameters:
- `COIN_FRAMES`, 4: frames the coin pulse is held high.
- `START_FRAMES`, 2: frames each start pulse is held high.
- `IDLE_FRAMES`, 120: inactivity frames before ownership is released; 8-bit counter.

Ports:
- `clk_sys`, in, 1: system clock (18 MHz domain). One clock only.
- `res_n_i`, in, 1: reset. Asynchronous, active-low.
- `kbjoy`, in, 10: keyboard joystick. Bits: 0 fire, 1 start1, 2 start2, 3 coin, 4 up, 5 down, 6 left, 7 right. Bits 9:8 unused.
- `joystick_0`, in, 8: joystick 0. Bits: 0 right, 1 left, 2 down, 3 up, 4 fire. Other bits unused.
- `joystick_1`, in, 8: joystick 1, same layout as `joystick_0`.
- `rotate`, in, 1: 1 = upright remap, 0 = normal.
- `vblank`, in, 1: core vertical blank. Its rising edge is the frame tick.
- `p1_csjudlr`, out, 7: {coin, start1, fire, 0, 0, left, right}.
- `p2_csjudlr`, out, 7: {0, start2, fire, 0, 0, down, up}.
- `owner`, out, 2: current owner. 0 NONE, 1 KBD, 2 JOY0, 3 JOY1.

## Operation
**Synchronization**
- All of `kbjoy`, `joystick_0`, `joystick_1`, `rotate` and `vblank` pass through 2-flop synchronizers.
- `frame_tick` is a one-cycle strobe on the synchronized `vblank` 0→1 transition.

**Canonical source vectors**
- Each source is reduced to a 5-bit vector {U, D, L, R, F}.
- A source is "active" when any of its 5 bits is set.

**Ownership FSM** (states NONE, KBD, JOY0, JOY1)
- NONE → first active source. On simultaneous activity, priority is KBD > JOY0 > JOY1.
- In an owned state, the idle counter clears whenever the owner is active. It increments on `frame_tick` while the owner is inactive.
- When the counter reaches `IDLE_FRAMES`, the FSM returns to NONE and the counter clears.
- Non-owner activity never preempts the owner.
- The selected vector is the owner's vector, or zeros in NONE. The grant cycle itself already uses the new owner's vector.

**Orientation**
- `rotate`=0: up=U, down=D, left=L, right=R.
- `rotate`=1: up=L, down=R, left=D, right=U.
- `fire` = selected F. The same `fire` drives both words.

**Coin/start pulses** (sub-module, three instances)
- Sources: coin = `kbjoy[3]`, start1 = `kbjoy[1]`, start2 = `kbjoy[2]`. These are independent of ownership.
- On a synchronized 0→1 edge of the key, the output goes high and a frame counter loads N.
- The counter decrements on each `frame_tick`. The output drops when it reaches 0.
- After the output drops, the instance is not re-armed until the key has been seen low.
- Edges arriving while the pulse is high are ignored.

## Timing
- Reset: all outputs 0, `owner`=NONE, all counters 0, synchronizers 0. Reset may arrive mid-pulse or mid-ownership; it returns everything to these values immediately.
- Direction/fire latency from input pin to output word: 3 `clk_sys` cycles (2 synchronizer + 1 output register).
- Coin/start latency to the rising output: 3 cycles.
- Pulse width: N to N+1 frames, depending on the phase of the key edge relative to `frame_tick`.
- Ownership release occurs on the `frame_tick` cycle on which the count reaches `IDLE_FRAMES`.
- If the owner is active on that same cycle, activity wins and the counter clears; no release happens.
- Release and re-grant: the FSM spends ≥1 cycle in NONE before any new grant.
- A `rotate` change takes effect 3 cycles after the input changes, with no glitch beyond the register boundary.

## Structure
- Package `blackhole_input_pkg` holds:
  - the owner enum;
  - bit-index localparams for the `kbjoy` and joystick layouts;
  - the 5-bit canonical vector typedef.
- Sub-module `input_pulse_gen`: synchronized key, `frame_tick`, parameter N → pulse. Instantiated three times.

## Test plan
- **Reset:** hold `res_n_i`=0 with all inputs high → both words 0 and `owner`=0. Release → `owner`=1 (KBD) within 3 cycles.
- **Arbitration:** `joystick_0`=0x01 and `joystick_1`=0x02 asserted in the same cycle → `owner`=2, `p1_csjudlr`=7'b0000001. Then `joystick_1` alone for 200 frames → `owner` stays 2 until 120 idle frames, then goes 0, then 3.
- **Coin pulse:** `kbjoy[3]` held high for 10 frames → `p1_csjudlr[6]` high for 4–5 frames exactly once. A second press during the pulse → no extension.
- **Rotation:** `rotate`=1, `joystick_0`=0x08 (up) → `p1_csjudlr[0]` (right)=1. With `rotate`=0, the same input → `p2_csjudlr[0]` (up)=1.
- **Idle boundary:** owner activity asserted on the exact 120th-frame tick → no release, counter reset.
- **Reset mid-operation:** assert reset mid start2 pulse → `p2_csjudlr[5]`=0 immediately. No pulse after release while the key is still held.
